// File: rtl/display_pkg.sv
// Shared definitions for the multi-digit display path.
// Holds the decoder code points used by the scan logic and the default
// digit count used by the scan multiplexer.
package display_pkg;

    // Decoder code points (the decoder renders 4'hB as an unlit digit)
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_A     = 4'hA;
    localparam logic [3:0] CODE_K     = 4'hC;
    localparam logic [3:0] CODE_L     = 4'hD;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_F     = 4'hF;

    localparam int DEFAULT_NUM_DIGITS = 4;

endpackage

// File: rtl/display_scan_mux_tick_divider.sv
// tick_divider: free-running modulo-DIV counter.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; clears the count
//   tick  - high during the cycle the count sits at DIV-1
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] count_r;

    // Terminal-count decode
    always_comb begin
        tick = (count_r == W'(DIV - 1));
    end

    // Count 0..DIV-1 and wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + W'(1);
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: scans a packed word of 4-bit display codes across
// NUM_DIGITS common-anode digits for the seven-segment decoder.
// Double-buffered (shadow -> active at frame wrap), optional leading-zero
// blanking, whole-display blink.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high
//   load        - strobe; captures digits_in into the shadow buffer
//   digits_in   - packed codes, [3:0] is digit 0 (rightmost)
//   lz_suppress - 1 = blank leading zeros
//   blink_en    - 1 = blink whole display
//   hex_out     - code for the active digit
//   an          - active-low one-hot digit enables
//   frame_start - one-cycle pulse on the first cycle of digit 0 after a wrap
//   pending     - shadow holds data not yet committed
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lz_suppress,
    input  logic                    blink_en,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    refresh_tick_s;
    logic                    blink_tick_s;
    logic                    wrap_s;
    logic [IDX_W-1:0]        index_r;
    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [4*NUM_DIGITS-1:0] active_r;
    logic                    blink_phase_r;
    logic [3:0]              disp_s [NUM_DIGITS];

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh_div (
        .clk   (clk),
        .reset (reset),
        .tick  (refresh_tick_s)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
        .clk   (clk),
        .reset (reset),
        .tick  (blink_tick_s)
    );

    // Frame wrap: refresh tick while the last digit is being shown
    always_comb begin
        wrap_s = refresh_tick_s && (index_r == IDX_W'(NUM_DIGITS - 1));
    end

    // Scan index, buffers, pending flag, frame pulse and blink phase.
    // A load coinciding with the commit tick: the commit uses the old shadow,
    // the new word lands in the shadow and pending stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_r       <= '0;
            shadow_r      <= {NUM_DIGITS{CODE_BLANK}};
            active_r      <= {NUM_DIGITS{CODE_BLANK}};
            pending       <= 1'b0;
            frame_start   <= 1'b0;
            blink_phase_r <= 1'b0;
        end else begin
            if (refresh_tick_s) begin
                index_r <= wrap_s ? '0 : index_r + IDX_W'(1);
            end
            frame_start <= wrap_s;
            if (wrap_s && pending) begin
                active_r <= shadow_r;
            end
            if (load) begin
                shadow_r <= digits_in;
                pending  <= 1'b1;
            end else if (wrap_s) begin
                pending  <= 1'b0;
            end
            if (blink_tick_s) begin
                blink_phase_r <= ~blink_phase_r;
            end
        end
    end

    // Leading-zero blanking: walk from the leftmost digit, blanking 4'h0
    // until the first non-zero code; letter codes count as non-zero and
    // digit 0 is always shown.
    always_comb begin : lz_blk
        logic       seen_nz;
        logic [3:0] code;
        seen_nz = 1'b0;
        code    = 4'h0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            code = active_r[i*4 +: 4];
            if (lz_suppress && !seen_nz && (code == 4'h0) && (i != 0)) begin
                disp_s[i] = CODE_BLANK;
            end else begin
                disp_s[i] = code;
            end
            if (code != 4'h0) begin
                seen_nz = 1'b1;
            end else begin
                seen_nz = seen_nz;
            end
        end
    end

    // Digit drive: decoded straight from the index register so an and
    // hex_out move on the same edge; blink blanks the code only.
    always_comb begin
        an = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << index_r);
        if (blink_en && blink_phase_r) begin
            hex_out = CODE_BLANK;
        end else begin
            hex_out = disp_s[index_r];
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digits_in;
    logic        lz_suppress;
    logic        blink_en;
    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        frame_start;
    logic        pending;

    int total = 0;
    int bad   = 0;
    int c     = 0;   // clock edges since reset release

    display_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .digits_in   (digits_in),
        .lz_suppress (lz_suppress),
        .blink_en    (blink_en),
        .hex_out     (hex_out),
        .an          (an),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    // advance until the position within the 16-cycle frame equals m
    task automatic step_to_mod(input int m);
        step();
        while ((c % 16) != m) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; digits_in = 16'h0000;
        lz_suppress = 1'b0; blink_en = 1'b0;
        step(); step();
        if (an !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b exp=%b", an, 4'b1110); end
        total++;
        if (hex_out !== 4'hB) begin bad++; $display("FAIL reset_hex got=%h exp=%h", hex_out, 4'hB); end
        total++;
        if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
        total++;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        total++;
        reset = 1'b0;
        c = 0;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL release_fs got=%b exp=0", frame_start); end
        total++;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] exp_an;
            step();
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            if ((i % 4) == 0) begin
                if (an !== exp_an) begin bad++; $display("FAIL scan_an c=%0d got=%b exp=%b", c, an, exp_an); end
                total++;
            end
        end
        if (frame_start !== 1'b1) begin bad++; $display("FAIL first_wrap_fs got=%b exp=1", frame_start); end
        total++;
        step();
        if (frame_start !== 1'b0) begin bad++; $display("FAIL fs_width got=%b exp=0", frame_start); end
        total++;
    endtask

    task automatic test_load_mid_frame();
        step_to_mod(5);                    // index 1
        load = 1'b1; digits_in = 16'h1234;
        step();
        load = 1'b0;
        if (pending !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", pending); end
        total++;
        if (hex_out !== 4'hB) begin bad++; $display("FAIL mid_hex_held got=%h exp=%h", hex_out, 4'hB); end
        total++;
        step_to_mod(15);
        if (hex_out !== 4'hB) begin bad++; $display("FAIL prewrap_hex got=%h exp=%h", hex_out, 4'hB); end
        total++;
        step();
        if (an !== 4'b1110) begin bad++; $display("FAIL commit_an got=%b exp=1110", an); end
        total++;
        if (hex_out !== 4'h4) begin bad++; $display("FAIL commit_hex got=%h exp=4", hex_out); end
        total++;
        if (pending !== 1'b0) begin bad++; $display("FAIL commit_pending got=%b exp=0", pending); end
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL commit_fs got=%b exp=1", frame_start); end
        total++;
        step();
        if (frame_start !== 1'b0) begin bad++; $display("FAIL commit_fs_end got=%b exp=0", frame_start); end
        total++;
        for (int d = 1; d < 4; d++) begin
            logic [15:0] ref_word;
            ref_word = 16'h1234;
            step_to_mod(4 * d);
            if (hex_out !== ref_word[d*4 +: 4]) begin
                bad++; $display("FAIL mid_digit%0d got=%h exp=%h", d, hex_out, ref_word[d*4 +: 4]);
            end
            total++;
        end
    endtask

    // load data in one frame, then check all four digits of the next frame
    task automatic commit_and_check(input [15:0] data, input logic lz, input [15:0] exp);
        step_to_mod(1);
        load = 1'b1; digits_in = data; lz_suppress = lz;
        step();
        load = 1'b0;
        step_to_mod(0);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] exp_an;
            if (d != 0) step_to_mod(4 * d);
            exp_an = ~(4'b0001 << d);
            if ((hex_out !== exp[d*4 +: 4]) || (an !== exp_an)) begin
                bad++;
                $display("FAIL frame data=%h lz=%b digit%0d got hex=%h an=%b exp hex=%h an=%b",
                         data, lz, d, hex_out, an, exp[d*4 +: 4], exp_an);
            end
            total++;
        end
    endtask

    task automatic test_lz_suppress();
        commit_and_check(16'h0070, 1'b1, 16'hBB70);
        commit_and_check(16'h0070, 1'b0, 16'h0070);
        commit_and_check(16'h0000, 1'b1, 16'hBBB0);
        commit_and_check(16'h0AE0, 1'b1, 16'hBAE0);
        lz_suppress = 1'b0;
    endtask

    task automatic test_blink();
        logic [15:0] word;
        word = 16'h1234;
        commit_and_check(word, 1'b0, word);
        blink_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [3:0] exp_hex;
            logic [3:0] exp_an;
            step();
            exp_an  = ~(4'b0001 << ((c / 4) % 4));
            exp_hex = (((c / 16) % 2) == 1) ? 4'hB : word[((c / 4) % 4) * 4 +: 4];
            if ((hex_out !== exp_hex) || (an !== exp_an)) begin
                bad++;
                $display("FAIL blink c=%0d got hex=%h an=%b exp hex=%h an=%b", c, hex_out, an, exp_hex, exp_an);
            end
            total++;
        end
        // disabling mid dark phase restores data at once
        step();
        while (!((((c / 16) % 2) == 1) && ((c % 16) == 5))) step();
        if (hex_out !== 4'hB) begin bad++; $display("FAIL blink_dark got=%h exp=%h", hex_out, 4'hB); end
        total++;
        blink_en = 1'b0;
        #1;
        if (hex_out !== 4'h3) begin bad++; $display("FAIL blink_off got=%h exp=3", hex_out); end
        total++;
    endtask

    task automatic test_load_on_commit();
        step_to_mod(1);
        load = 1'b1; digits_in = 16'hACDE;
        step();
        load = 1'b0;
        step_to_mod(15);
        load = 1'b1; digits_in = 16'hEF00;
        step();
        load = 1'b0;
        if ((hex_out !== 4'hE) || (pending !== 1'b1) || (frame_start !== 1'b1)) begin
            bad++;
            $display("FAIL cc_wrap got hex=%h pend=%b fs=%b exp hex=e pend=1 fs=1", hex_out, pending, frame_start);
        end
        total++;
        for (int d = 1; d < 4; d++) begin
            logic [15:0] w;
            w = 16'hACDE;
            step_to_mod(4 * d);
            if ((hex_out !== w[d*4 +: 4]) || (pending !== 1'b1)) begin
                bad++; $display("FAIL cc_first digit%0d got hex=%h pend=%b exp hex=%h pend=1", d, hex_out, pending, w[d*4 +: 4]);
            end
            total++;
        end
        for (int d = 0; d < 4; d++) begin
            logic [15:0] w;
            w = 16'hEF00;
            step_to_mod(4 * d);
            if ((hex_out !== w[d*4 +: 4]) || (pending !== 1'b0)) begin
                bad++; $display("FAIL cc_second digit%0d got hex=%h pend=%b exp hex=%h pend=0", d, hex_out, pending, w[d*4 +: 4]);
            end
            total++;
        end
    endtask

    task automatic test_reset_mid();
        step_to_mod(1);
        load = 1'b1; digits_in = 16'h5678;
        step();
        load = 1'b0;
        step_to_mod(8);
        if (pending !== 1'b1) begin bad++; $display("FAIL rm_pre_pending got=%b exp=1", pending); end
        total++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        c = 0;
        if ((pending !== 1'b0) || (an !== 4'b1110) || (hex_out !== 4'hB)) begin
            bad++; $display("FAIL rm_after got pend=%b an=%b hex=%h exp pend=0 an=1110 hex=b", pending, an, hex_out);
        end
        total++;
        for (int k = 1; k < 8; k++) begin
            logic [3:0] exp_an;
            step_to_mod((4 * k) % 16);
            exp_an = ~(4'b0001 << (k % 4));
            if ((hex_out !== 4'hB) || (an !== exp_an) || (pending !== 1'b0)) begin
                bad++; $display("FAIL rm_blank k=%0d got hex=%h an=%b pend=%b exp hex=b an=%b pend=0", k, hex_out, an, pending, exp_an);
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_lz_suppress();
        test_blink();
        test_load_on_commit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
